// File: rtl/btn_click_decoder.sv
// ---------------------------------------------------------------------------
// btn_click_decoder
// Converts raw mouse position and left-button level into one-cycle
// DEAL / HIT / STAND command pulses, and reports which enabled button is
// under the cursor (hover) and which button is currently armed (pressed).
//
// Ports:
//   clk      in   system (pixel) clock
//   rst      in   asynchronous active-high reset
//   xpos     in   [11:0] mouse x, asynchronous to clk
//   ypos     in   [11:0] mouse y, asynchronous to clk
//   left     in   mouse left-button level, asynchronous to clk
//   phase    in   0 = betting (DEAL enabled), 1 = playing (HIT/STAND enabled)
//   deal     out  one-cycle DEAL pulse
//   hit      out  one-cycle HIT pulse
//   stand    out  one-cycle STAND pulse
//   hover    out  [1:0] enabled button under cursor (0 none,1 DEAL,2 HIT,3 STAND)
//   pressed  out  [1:0] armed button, 0 when not armed
// ---------------------------------------------------------------------------
module btn_click_decoder #(
   parameter int BTN1_X          = 100,
   parameter int BTN2_X          = 300,
   parameter int BTN3_X          = 500,
   parameter int BTN_Y           = 400,
   parameter int BTN_W           = 100,
   parameter int BTN_H           = 50,
   parameter int COOLDOWN_CYCLES = 4_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        left,
   input  logic        phase,
   output logic        deal,
   output logic        hit,
   output logic        stand,
   output logic [1:0]  hover,
   output logic [1:0]  pressed
);

   localparam int              CNT_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

   // 13-bit bounds so that left edge + width cannot wrap
   localparam logic [12:0] X1_LO = 13'(BTN1_X);
   localparam logic [12:0] X1_HI = 13'(BTN1_X + BTN_W);
   localparam logic [12:0] X2_LO = 13'(BTN2_X);
   localparam logic [12:0] X2_HI = 13'(BTN2_X + BTN_W);
   localparam logic [12:0] X3_LO = 13'(BTN3_X);
   localparam logic [12:0] X3_HI = 13'(BTN3_X + BTN_W);
   localparam logic [12:0] Y_LO  = 13'(BTN_Y);
   localparam logic [12:0] Y_HI  = 13'(BTN_Y + BTN_H);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_BLOCKED  = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   // Button code is enabled in the given phase
   function automatic logic btn_enabled(input logic [1:0] code, input logic ph);
      logic en;
      case (code)
         2'd1:    en = ~ph;
         2'd2:    en = ph;
         2'd3:    en = ph;
         default: en = 1'b0;
      endcase
      return en;
   endfunction

   logic [11:0]      r_x_m, r_x_s, r_y_m, r_y_s;
   logic             r_left_m, r_left_s, r_left_prev;
   state_t           r_state, w_state_nxt;
   logic [1:0]       r_armed, w_armed_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_deal, r_hit, r_stand;
   logic [1:0]       r_hover, r_pressed;

   logic [12:0]      w_x, w_y;
   logic             w_in_y;
   logic [1:0]       w_r, w_re;
   logic             w_rise, w_fall;
   logic [1:0]       w_cmd;
   logic [1:0]       w_pressed_nxt;

   // Two-flop alignment of the asynchronous mouse inputs; all three move together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x_m       <= 12'd0;
         r_x_s       <= 12'd0;
         r_y_m       <= 12'd0;
         r_y_s       <= 12'd0;
         r_left_m    <= 1'b0;
         r_left_s    <= 1'b0;
         r_left_prev <= 1'b0;
      end else begin
         r_x_m       <= xpos;
         r_x_s       <= r_x_m;
         r_y_m       <= ypos;
         r_y_s       <= r_y_m;
         r_left_m    <= left;
         r_left_s    <= r_left_m;
         r_left_prev <= r_left_s;
      end
   end

   assign w_x    = {1'b0, r_x_s};
   assign w_y    = {1'b0, r_y_s};
   assign w_in_y = (w_y >= Y_LO) && (w_y < Y_HI);
   assign w_rise = r_left_s & ~r_left_prev;
   assign w_fall = ~r_left_s & r_left_prev;

   // Hit-test against the button rectangles, then mask by phase enable
   always_comb begin
      w_r = 2'd0;
      if (w_in_y && (w_x >= X1_LO) && (w_x < X1_HI)) begin
         w_r = 2'd1;
      end else if (w_in_y && (w_x >= X2_LO) && (w_x < X2_HI)) begin
         w_r = 2'd2;
      end else if (w_in_y && (w_x >= X3_LO) && (w_x < X3_HI)) begin
         w_r = 2'd3;
      end else begin
         w_r = 2'd0;
      end
      if (btn_enabled(w_r, phase)) begin
         w_re = w_r;
      end else begin
         w_re = 2'd0;
      end
   end

   // State register with armed button and cooldown counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_armed <= 2'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_armed <= w_armed_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_armed_nxt = r_armed;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_rise && (w_re != 2'd0)) begin
               w_state_nxt = S_ARMED;
               w_armed_nxt = w_re;
            end else if (w_rise) begin
               w_state_nxt = S_BLOCKED;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ARMED: begin
            // A phase change disarms before a same-cycle release is considered
            if (!btn_enabled(r_armed, phase)) begin
               w_state_nxt = S_BLOCKED;
            end else if (w_fall && (w_re == r_armed)) begin
               w_state_nxt = S_COOLDOWN;
               w_cnt_nxt   = CNT_LOAD;
            end else if (w_fall) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ARMED;
            end
         end
         S_BLOCKED: begin
            if (w_fall) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BLOCKED;
            end
         end
         S_COOLDOWN: begin
            // A press begun during lockout must be released before it counts
            if (r_cnt == '0) begin
               w_state_nxt = r_left_s ? S_BLOCKED : S_IDLE;
            end else begin
               w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_armed_nxt = 2'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode: command to fire on this edge and next pressed code
   always_comb begin
      w_cmd = 2'd0;
      if ((r_state == S_ARMED) && btn_enabled(r_armed, phase) && w_fall && (w_re == r_armed)) begin
         w_cmd = r_armed;
      end else begin
         w_cmd = 2'd0;
      end
      if (w_state_nxt == S_ARMED) begin
         w_pressed_nxt = w_armed_nxt;
      end else begin
         w_pressed_nxt = 2'd0;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deal    <= 1'b0;
         r_hit     <= 1'b0;
         r_stand   <= 1'b0;
         r_hover   <= 2'd0;
         r_pressed <= 2'd0;
      end else begin
         r_deal    <= (w_cmd == 2'd1);
         r_hit     <= (w_cmd == 2'd2);
         r_stand   <= (w_cmd == 2'd3);
         r_hover   <= w_re;
         r_pressed <= w_pressed_nxt;
      end
   end

   assign deal    = r_deal;
   assign hit     = r_hit;
   assign stand   = r_stand;
   assign hover   = r_hover;
   assign pressed = r_pressed;

endmodule

// File: tb/tb_btn_click_decoder.sv
// ---------------------------------------------------------------------------
// tb_btn_click_decoder
// Directed bench for btn_click_decoder with COOLDOWN_CYCLES = 8. Expected
// command pulses are queued (cycle + one-hot command) when the release is
// driven and matched against pulses seen on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_btn_click_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic        left, phase;
   logic        deal, hit, stand;
   logic [1:0]  hover, pressed;

   always #5 clk = ~clk;

   btn_click_decoder #(
      .BTN1_X(100), .BTN2_X(300), .BTN3_X(500), .BTN_Y(400),
      .BTN_W(100), .BTN_H(50), .COOLDOWN_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left), .phase(phase),
      .deal(deal), .hit(hit), .stand(stand), .hover(hover), .pressed(pressed)
   );

   typedef struct {
      int         cyc;
      logic [2:0] cmd;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // {deal,hit,stand} pattern for a command code
   function automatic logic [2:0] onehot(input int c);
      logic [2:0] v;
      case (c)
         1:       v = 3'b100;
         2:       v = 3'b010;
         3:       v = 3'b001;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   // One clock cycle; pulses are checked against the scoreboard at the falling edge
   task automatic step();
      exp_t       e;
      logic [2:0] w;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      w = {deal, hit, stand};
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk("missed_pulse_cycle", cyc, e.cyc);
      end
      if (w != 3'b000) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", w, 3'b000);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_cmd", w, e.cmd);
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic expect_pulse(input int c);
      sb.push_back('{cyc + 3, onehot(c)});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_deal"}, deal, 0);
      chk({tag, "_hit"}, hit, 0);
      chk({tag, "_stand"}, stand, 0);
      chk({tag, "_hover"}, hover, 0);
      chk({tag, "_pressed"}, pressed, 0);
   endtask

   // Press at (x,y), hold, check hover/pressed, release, then idle past cooldown
   task automatic click(input int x, input int y, input int hold,
                        input int exp_hover, input int exp_pressed, input int exp_cmd);
      xpos = 12'(x);
      ypos = 12'(y);
      steps(4);
      left = 1'b1;
      steps(hold);
      chk("hover_hold", hover, exp_hover);
      chk("pressed_hold", pressed, exp_pressed);
      left = 1'b0;
      if (exp_cmd != 0) expect_pulse(exp_cmd);
      steps(14);
   endtask

   initial begin
      rst   = 1'b1;
      left  = 1'b0;
      xpos  = 12'd0;
      ypos  = 12'd0;
      phase = 1'b0;
      steps(3);
      chk_all_zero("reset");
      rst = 1'b0;
      steps(3);

      // DEAL click in betting phase
      click(150, 420, 10, 1, 1, 1);
      // HIT is disabled in betting phase: blocked, no pulse
      click(350, 420, 10, 0, 0, 0);

      // Playing phase: drag from STAND to HIT releases on wrong button
      phase = 1'b1;
      xpos = 12'd550; ypos = 12'd425;
      steps(4);
      left = 1'b1;
      steps(6);
      chk("drag_hover_start", hover, 3);
      chk("drag_pressed_start", pressed, 3);
      xpos = 12'd350;
      steps(5);
      chk("drag_hover_hit", hover, 2);
      chk("drag_pressed_kept", pressed, 3);
      left = 1'b0;
      steps(14);

      // Release on the last pixel inside STAND fires
      xpos = 12'd550; ypos = 12'd425;
      steps(4);
      left = 1'b1;
      steps(5);
      xpos = 12'd599; ypos = 12'd449;
      steps(5);
      chk("edge_in_hover", hover, 3);
      left = 1'b0;
      expect_pulse(3);
      steps(14);

      // Release one pixel right of STAND does not
      xpos = 12'd550; ypos = 12'd425;
      steps(4);
      left = 1'b1;
      steps(5);
      xpos = 12'd600;
      steps(5);
      chk("edge_out_hover", hover, 0);
      chk("edge_out_pressed", pressed, 3);
      left = 1'b0;
      steps(14);

      // Cooldown: a quick second click is ignored
      xpos = 12'd350; ypos = 12'd420;
      steps(4);
      left = 1'b1;
      steps(4);
      left = 1'b0;
      expect_pulse(2);
      steps(1);
      left = 1'b1;
      steps(3);
      left = 1'b0;
      steps(14);

      // Cooldown: button held through lockout end is blocked
      left = 1'b1;
      steps(4);
      left = 1'b0;
      expect_pulse(2);
      steps(1);
      left = 1'b1;
      steps(20);
      chk("held_after_cooldown_pressed", pressed, 0);
      left = 1'b0;
      steps(14);
      click(350, 420, 6, 2, 2, 2);

      // Phase drops while HIT is armed
      left = 1'b1;
      steps(6);
      chk("phase_drop_pressed_before", pressed, 2);
      phase = 1'b0;
      steps(1);
      chk("phase_drop_pressed_after", pressed, 0);
      chk("phase_drop_hover_after", hover, 0);
      left = 1'b0;
      steps(14);

      // Reset while ARMED
      xpos = 12'd150; ypos = 12'd420;
      steps(4);
      left = 1'b1;
      steps(6);
      chk("armed_pressed_before_rst", pressed, 1);
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_armed");
      steps(3);
      xpos = 12'd10; ypos = 12'd10;
      rst = 1'b0;
      steps(4);
      left = 1'b0;
      steps(6);
      click(150, 420, 6, 1, 1, 1);

      // Reset during COOLDOWN, then an immediate click must fire
      steps(4);
      left = 1'b1;
      steps(5);
      left = 1'b0;
      expect_pulse(1);
      steps(5);
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_cooldown");
      steps(2);
      rst = 1'b0;
      steps(2);
      click(150, 420, 6, 1, 1, 1);

      steps(4);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
